// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: default widths, FSM state
// encodings, redirect-source selector and the alignment helper.
package pc_fetch_ctrl_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_FLUSH  = 2'd3
    } redir_sel_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Next-PC priority mux (flush > jump > branch > sequential) with alignment
// check. Redirect targets are forced word-aligned; the sequential PC is not.
module pc_fetch_ctrl_next_pc_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] siguiente,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_target,
    output logic [PC_W-1:0] next_pc,
    output logic            misalign
);

    redir_sel_e      sel;
    logic [PC_W-1:0] raw_pc;

    always_comb begin
        sel = SEL_SEQ;
        if (flush) begin
            sel = SEL_FLUSH;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (branch_taken) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        raw_pc = siguiente;
        case (sel)
            SEL_FLUSH:  raw_pc = flush_target;
            SEL_JUMP:   raw_pc = jump_target;
            SEL_BRANCH: raw_pc = branch_target;
            default:    raw_pc = siguiente;
        endcase
    end

    // siguiente comes from add_pc4 and is trusted as-is, including its wrap.
    assign misalign = (sel != SEL_SEQ) && is_misaligned(raw_pc[1:0]);
    assign next_pc  = (sel == SEL_SEQ) ? raw_pc : {raw_pc[PC_W-1:2], 2'b00};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch sequencer: IDLE/REQ/HOLD FSM with a
// req/ack memory handshake, timeout, and flush/jump/branch redirects.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = 0,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    siguiente,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_target,
    input  logic               stall,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    pc_out,
    output logic               imem_req,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   wait_q, wait_d;

    logic [PC_W-1:0]    sel_pc;
    logic               sel_misalign;

    pc_fetch_ctrl_next_pc_sel #(
        .PC_W(PC_W)
    ) u_next_pc_sel (
        .siguiente    (siguiente),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .flush        (flush),
        .flush_target (flush_target),
        .next_pc      (sel_pc),
        .misalign     (sel_misalign)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        wait_d  = wait_q;

        if (flush) begin
            // Flush wins over stall and over a same-cycle ack (word dropped).
            pc_d    = sel_pc;
            err_d   = sel_misalign;
            valid_d = 1'b0;
            wait_d  = '0;
            state_d = ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wait_d  = '0;
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr_d = instr_in;
                        valid_d = 1'b1;
                        wait_d  = '0;
                        state_d = ST_HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        // Give up; IDLE re-requests the same PC next cycle.
                        err_d   = 1'b1;
                        wait_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc_d    = sel_pc;
                        err_d   = sel_misalign;
                        valid_d = 1'b0;
                        wait_d  = '0;
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    wait_d  = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_W'(RESET_PC);
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
        end
    end

    assign pc_out      = pc_q;
    assign imem_req    = req_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule
